serial_add_ctrl: RTL

- Bit-serial adder controller. Captures two WIDTH-bit operands on a start request, then pushes them one bit per cycle, LSB first, through a single full-adder cell built from two half_adder instances.
- Owns the sequencing FSM, operand shift registers, the carry flip-flop, the bit counter and the result register.
- Trades area for latency: used wherever a narrow add is needed and a parallel adder is not justified.

---
 rtl/serial_add_pkg.sv | 13 +
 rtl/half_adder.sv | 12 +
 rtl/serial_fa.sv | 31 +++
 rtl/serial_add_ctrl.sv | 126 ++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared types and limits for the bit-serial adder controller.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } sa_state_t;

  // Largest operand width the controller is meant to be built with.
  localparam int SA_MAX_WIDTH = 32;

endpackage : serial_add_pkg

// File: rtl/half_adder.sv
// One-bit half adder: the primitive cell of the serial datapath.
module half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;

endmodule : half_adder

// File: rtl/serial_fa.sv
// One-bit full adder built from two half adders plus an OR of their carries.
module serial_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  logic s0;
  logic c0;
  logic c1;

  half_adder u_ha0 (
    .a_i (a_i),
    .b_i (b_i),
    .s_o (s0),
    .c_o (c0)
  );

  half_adder u_ha1 (
    .a_i (s0),
    .b_i (c_i),
    .s_o (s_o),
    .c_o (c1)
  );

  // The two half-adder carries can never both be 1, so OR completes the cell.
  assign c_o = c0 | c1;

endmodule : serial_fa

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: captures two operands on start, adds them LSB
// first through a single full-adder cell, and holds the result until the
// next accepted start.
// Optional macro SERIAL_ADD_SUBTRACT_EN adds a 'sub' input that turns the
// operation into a - b (B inverted, initial carry 1).
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef SERIAL_ADD_SUBTRACT_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  sa_state_t        state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] res_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] s_q;
  logic             cout_q;

  logic             fa_b_d;
  logic             sum_d;
  logic             carry_d;
  logic             carry_init_d;

`ifdef SERIAL_ADD_SUBTRACT_EN
  logic             sub_q;

  // Subtraction is a + ~b + 1: invert the B bit and seed the carry with 1.
  assign fa_b_d       = b_sh_q[0] ^ sub_q;
  assign carry_init_d = sub;
`else
  assign fa_b_d       = b_sh_q[0];
  assign carry_init_d = 1'b0;
`endif

  serial_fa u_fa (
    .a_i (a_sh_q[0]),
    .b_i (fa_b_d),
    .c_i (carry_q),
    .s_o (sum_d),
    .c_o (carry_d)
  );

  // Sequencing FSM with operand shifters, carry, counter and registered outputs.
  // NOTE: every register here uses <= so all updates see pre-edge values;
  // blocking assignments would let the shifters and result race each other.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADD_SUBTRACT_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            res_q   <= '0;
            carry_q <= carry_init_d;
            cnt_q   <= '0;
`ifdef SERIAL_ADD_SUBTRACT_EN
            sub_q   <= sub;
`endif
            busy_q  <= 1'b1;
            state_q <= ADD;
          end
        end
        ADD: begin
          // Sum bits enter at the MSB so after WIDTH shifts bit i sits at i.
          res_q   <= {sum_d, res_q[WIDTH-1:1]};
          a_sh_q  <= a_sh_q >> 1;
          b_sh_q  <= b_sh_q >> 1;
          carry_q <= carry_d;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            s_q     <= {sum_d, res_q[WIDTH-1:1]};
            cout_q  <= carry_d;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign s    = s_q;
  assign cout = cout_q;

endmodule : serial_add_ctrl
